// File: rtl/pipe5_wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order writeback stage and a
// one-entry buffered MDU result, with starvation forcing and WAW suppression.
module pipe5_wb_port_arbiter #(
  parameter int WORD_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wb_valid,
  input  logic              wb_wen,
  input  logic [4:0]        wb_rd,
  input  logic [WORD_W-1:0] wb_wdata,
  output logic              wb_stall,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_rd,
  input  logic [WORD_W-1:0] mdu_wdata,
  output logic              mdu_ready,
  output logic              rf_wen,
  output logic [4:0]        rf_rd,
  output logic [WORD_W-1:0] rf_wdata,
  output logic              pend_valid,
  output logic [4:0]        pend_rd
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  logic              buf_valid;
  logic [4:0]        buf_rd;
  logic [WORD_W-1:0] buf_wdata;
  logic [3:0]        starve_cnt;

  logic wb_need;
  logic force_buf;
  logic grant_buf;
  logic grant_wb;
  logic waw_drop;
  logic buf_release;
  logic load;

  always_comb begin
    wb_need     = wb_valid & wb_wen & (wb_rd != 5'd0);
    force_buf   = buf_valid & (starve_cnt == STARVE_LIMIT);
    grant_buf   = force_buf | (~wb_need & buf_valid);
    grant_wb    = ~force_buf & wb_need;
    // A younger writeback to the same register makes the buffered result dead.
    waw_drop    = grant_wb & buf_valid & (wb_rd == buf_rd);
    buf_release = grant_buf | waw_drop;
  end

  // MDU handshake: a result transfers on an edge where mdu_valid & mdu_ready;
  // mdu_ready depends only on registered state and writeback inputs, and the
  // MDU keeps mdu_rd/mdu_wdata stable while mdu_valid & ~mdu_ready.
  always_comb begin
    mdu_ready = ~RST & (~buf_valid | buf_release);
    load      = mdu_valid & mdu_ready;
    wb_stall  = ~RST & force_buf & wb_need;
    rf_wen    = ~RST & (grant_wb | (grant_buf & (buf_rd != 5'd0)));
    rf_rd     = grant_buf ? buf_rd : wb_rd;
    rf_wdata  = grant_buf ? buf_wdata : wb_wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_valid <= 1'b0;
      buf_rd    <= 5'd0;
      buf_wdata <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_rd    <= mdu_rd;
      buf_wdata <= mdu_wdata;
    end else if (buf_release) begin
      buf_valid <= 1'b0;
    end
  end

  // Counts arbitration losses of the current buffered result; saturates at the force point.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= 4'd0;
    end else if (!buf_valid || buf_release || load) begin
      starve_cnt <= 4'd0;
    end else if (grant_wb && starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign pend_valid = buf_valid;
  assign pend_rd    = buf_rd;

endmodule

// File: tb/tb_pipe5_wb_port_arbiter.sv
// Bench for pipe5_wb_port_arbiter: directed scenarios with hand-derived
// expectations plus a randomized run against a rule-level reference model.
module tb_pipe5_wb_port_arbiter;
  localparam int W = 32;
  localparam int MAXS = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          wb_valid = 1'b0, wb_wen = 1'b0;
  logic [4:0]    wb_rd = '0;
  logic [W-1:0]  wb_wdata = '0;
  logic          wb_stall;
  logic          mdu_valid = 1'b0;
  logic [4:0]    mdu_rd = '0;
  logic [W-1:0]  mdu_wdata = '0;
  logic          mdu_ready, rf_wen, pend_valid;
  logic [4:0]    rf_rd, pend_rd;
  logic [W-1:0]  rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W+4:0] exp_q[$];

  // reference model: at most one waiting MDU result and how often it has lost
  bit           m_has;
  logic [4:0]   m_rd;
  logic [W-1:0] m_data;
  int           m_lost;
  bit           e_wen, e_stall, e_ready, buf_leaves, wb_wins;
  logic [4:0]   e_rd;
  logic [W-1:0] e_data;

  pipe5_wb_port_arbiter #(.WORD_W(W), .MAX_STARVE(MAXS)) dut (
    .CLK(CLK), .RST(RST),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_rd(pend_rd)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wb_drive(input bit v, input logic [4:0] rd, input logic [W-1:0] d);
    wb_valid = v; wb_wen = v; wb_rd = rd; wb_wdata = d;
  endtask

  task automatic mdu_drive(input bit v, input logic [4:0] rd, input logic [W-1:0] d);
    mdu_valid = v; mdu_rd = rd; mdu_wdata = d;
  endtask

  task automatic do_reset();
    wb_drive(0, 0, 0); mdu_drive(0, 0, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  function automatic void model_clear();
    m_has = 0; m_rd = '0; m_data = '0; m_lost = 0;
  endfunction

  function automatic void model_eval();
    bit need;
    need = wb_valid && wb_wen && (wb_rd != 0);
    e_stall = 0; buf_leaves = 0; wb_wins = 0; e_wen = 0; e_rd = '0; e_data = '0;
    if (m_has && m_lost >= MAXS) begin
      buf_leaves = 1; e_stall = need;
    end else if (need) begin
      wb_wins = 1;
      if (m_has && m_rd == wb_rd) buf_leaves = 1;
    end else if (m_has) begin
      buf_leaves = 1;
    end
    if (wb_wins) begin
      e_wen = 1; e_rd = wb_rd; e_data = wb_wdata;
    end else if (buf_leaves) begin
      e_wen = (m_rd != 0); e_rd = m_rd; e_data = m_data;
    end
    e_ready = !m_has || buf_leaves;
  endfunction

  function automatic void model_commit();
    bit took;
    took = mdu_valid && e_ready;
    if (buf_leaves) m_has = 0;
    else if (m_has) m_lost++;
    if (took) begin
      m_has = 1; m_rd = mdu_rd; m_data = mdu_wdata; m_lost = 0;
    end
  endfunction

  task automatic test_reset();
    wb_drive(1, 5'd3, 32'h33); mdu_drive(1, 5'd4, 32'h44);
    RST = 1'b1;
    #2;
    n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen: got %b exp 0", rf_wen); end
    n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wb_stall: got %b exp 0", wb_stall); end
    n_tests++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_ready: got %b exp 0", mdu_ready); end
    n_tests++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend_valid: got %b exp 0", pend_valid); end
    n_tests++; if (pend_rd !== 5'd0) begin n_fail++; $display("FAIL reset_pend_rd: got %0d exp 0", pend_rd); end
    tick();
    wb_drive(0, 0, 0); mdu_drive(0, 0, 0);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_idle_port();
    mdu_drive(1, 5'd5, 32'hDEADBEEF);
    @(negedge CLK);
    n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready0: got %b exp 1", mdu_ready); end
    n_tests++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL idle_wen0: got %b exp 0", rf_wen); end
    tick();
    mdu_drive(0, 0, 0);
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL idle_wen1: got %b exp 1", rf_wen); end
    n_tests++; if (rf_rd !== 5'd5) begin n_fail++; $display("FAIL idle_rd: got %0d exp 5", rf_rd); end
    n_tests++; if (rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL idle_data: got %h exp deadbeef", rf_wdata); end
    n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready1: got %b exp 1", mdu_ready); end
    n_tests++; if (pend_valid !== 1'b1 || pend_rd !== 5'd5) begin n_fail++; $display("FAIL idle_pend: got %b/%0d exp 1/5", pend_valid, pend_rd); end
    tick();
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b0 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after: got wen %b pend %b exp 0/0", rf_wen, pend_valid); end
    tick();
  endtask

  task automatic test_starvation();
    mdu_drive(1, 5'd7, 32'h77);
    tick();
    mdu_drive(0, 0, 0);
    for (int i = 1; i <= MAXS; i++) begin
      wb_drive(1, 5'(i), 32'h100 + i);
      @(negedge CLK);
      n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'(i) || wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_wb%0d: got wen %b rd %0d stall %b exp 1/%0d/0", i, rf_wen, rf_rd, wb_stall, i); end
      n_tests++; if (mdu_ready !== 1'b0 || pend_valid !== 1'b1) begin n_fail++; $display("FAIL starve_hold%0d: got ready %b pend %b exp 0/1", i, mdu_ready, pend_valid); end
      tick();
    end
    wb_drive(1, 5'd5, 32'h105);
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h77) begin n_fail++; $display("FAIL starve_force: got wen %b rd %0d data %h exp 1/7/77", rf_wen, rf_rd, rf_wdata); end
    n_tests++; if (wb_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %b exp 1", wb_stall); end
    tick();
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || wb_stall !== 1'b0 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL starve_resume: got wen %b rd %0d stall %b pend %b exp 1/5/0/0", rf_wen, rf_rd, wb_stall, pend_valid); end
    tick();
    wb_drive(0, 0, 0);
    tick();
  endtask

  task automatic test_waw();
    mdu_drive(1, 5'd9, 32'h11);
    tick();
    mdu_drive(0, 0, 0);
    wb_drive(1, 5'd9, 32'h22);
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h22) begin n_fail++; $display("FAIL waw_write: got wen %b rd %0d data %h exp 1/9/22", rf_wen, rf_rd, rf_wdata); end
    n_tests++; if (wb_stall !== 1'b0 || mdu_ready !== 1'b1) begin n_fail++; $display("FAIL waw_ctl: got stall %b ready %b exp 0/1", wb_stall, mdu_ready); end
    tick();
    wb_drive(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_tests++; if (rf_wen !== 1'b0 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL waw_stale%0d: got wen %b pend %b exp 0/0", i, rf_wen, pend_valid); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W+4:0] got;
    exp_q.delete();
    for (int i = 3; i <= 5; i++) exp_q.push_back({5'(i), 32'hA0 + i});
    for (int c = 0; c < 5; c++) begin
      if (c < 3) mdu_drive(1, 5'(c + 3), 32'hA0 + c + 3);
      else mdu_drive(0, 0, 0);
      @(negedge CLK);
      if (c < 3) begin
        n_tests++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b exp 1", c, mdu_ready); end
      end
      n_tests++; if (rf_wen !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL b2b_wen%0d: got %b exp %b", c, rf_wen, (c >= 1 && c <= 3)); end
      if (rf_wen === 1'b1) begin
        got = {rf_rd, rf_wdata};
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got %h exp none", got); end
        else if (got !== exp_q[0]) begin n_fail++; $display("FAIL b2b_order: got %h exp %h", got, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
      end
      tick();
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_full_buffer();
    mdu_drive(1, 5'd12, 32'hC0C0);
    tick();
    mdu_drive(1, 5'd8, 32'h8888);
    wb_drive(1, 5'd2, 32'h2222);
    @(negedge CLK);
    n_tests++; if (mdu_ready !== 1'b0 || rf_rd !== 5'd2) begin n_fail++; $display("FAIL full_block: got ready %b rd %0d exp 0/2", mdu_ready, rf_rd); end
    tick();
    wb_drive(0, 0, 0);
    @(negedge CLK);
    n_tests++; if (mdu_ready !== 1'b1 || rf_wen !== 1'b1 || rf_rd !== 5'd12) begin n_fail++; $display("FAIL full_drain: got ready %b wen %b rd %0d exp 1/1/12", mdu_ready, rf_wen, rf_rd); end
    tick();
    mdu_drive(0, 0, 0);
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'd8 || rf_wdata !== 32'h8888) begin n_fail++; $display("FAIL full_refill: got wen %b rd %0d data %h exp 1/8/8888", rf_wen, rf_rd, rf_wdata); end
    tick();
  endtask

  task automatic test_rd_zero();
    mdu_drive(1, 5'd11, 32'hB);
    tick();
    mdu_drive(1, 5'd0, 32'hF00D);
    wb_drive(1, 5'd0, 32'h1);
    @(negedge CLK);
    n_tests++; if (rf_rd !== 5'd11 || wb_stall !== 1'b0 || mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_wb: got rd %0d stall %b ready %b exp 11/0/1", rf_rd, wb_stall, mdu_ready); end
    tick();
    mdu_drive(0, 0, 0); wb_drive(0, 0, 0);
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b0 || pend_valid !== 1'b1 || mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_drop: got wen %b pend %b ready %b exp 0/1/1", rf_wen, pend_valid, mdu_ready); end
    tick();
  endtask

  task automatic test_reset_mid();
    mdu_drive(1, 5'd13, 32'hD);
    tick();
    mdu_drive(1, 5'd14, 32'hE);
    wb_drive(1, 5'd1, 32'h1);
    @(negedge CLK);
    n_tests++; if (pend_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %b exp 1", pend_valid); end
    RST = 1'b1;
    #1;
    n_tests++; if (pend_valid !== 1'b0 || rf_wen !== 1'b0 || mdu_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got pend %b wen %b ready %b exp 0/0/0", pend_valid, rf_wen, mdu_ready); end
    tick();
    mdu_drive(0, 0, 0); wb_drive(0, 0, 0);
    RST = 1'b0;
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b0 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got wen %b pend %b exp 0/0", rf_wen, pend_valid); end
    tick();
    mdu_drive(1, 5'd6, 32'h66);
    tick();
    mdu_drive(0, 0, 0);
    @(negedge CLK);
    n_tests++; if (rf_wen !== 1'b1 || rf_rd !== 5'd6 || rf_wdata !== 32'h66) begin n_fail++; $display("FAIL rmid_post: got wen %b rd %0d data %h exp 1/6/66", rf_wen, rf_rd, rf_wdata); end
    tick();
  endtask

  task automatic test_random();
    bit hold_wb, hold_mdu;
    do_reset();
    model_clear();
    hold_wb = 0; hold_mdu = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold_wb) begin
        wb_valid = ($urandom_range(0, 9) < 8);
        wb_wen = ($urandom_range(0, 7) != 0);
        wb_rd = 5'($urandom_range(0, 7));
        wb_wdata = $urandom;
      end
      if (!hold_mdu) begin
        mdu_valid = ($urandom_range(0, 2) != 0);
        mdu_rd = 5'($urandom_range(0, 7));
        mdu_wdata = $urandom;
      end
      @(negedge CLK);
      model_eval();
      n_tests++; if (rf_wen !== e_wen) begin n_fail++; $display("FAIL rnd_wen c%0d: got %b exp %b", c, rf_wen, e_wen); end
      if (e_wen) begin
        n_tests++; if (rf_rd !== e_rd || rf_wdata !== e_data) begin n_fail++; $display("FAIL rnd_port c%0d: got %0d/%h exp %0d/%h", c, rf_rd, rf_wdata, e_rd, e_data); end
      end
      n_tests++; if (wb_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b exp %b", c, wb_stall, e_stall); end
      n_tests++; if (mdu_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, mdu_ready, e_ready); end
      n_tests++; if (pend_valid !== m_has || (m_has && pend_rd !== m_rd)) begin n_fail++; $display("FAIL rnd_pend c%0d: got %b/%0d exp %b/%0d", c, pend_valid, pend_rd, m_has, m_rd); end
      hold_wb = e_stall;
      hold_mdu = mdu_valid && !e_ready;
      model_commit();
      tick();
    end
    wb_drive(0, 0, 0); mdu_drive(0, 0, 0);
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_idle_port();
    test_starvation();
    test_waw();
    test_back_to_back();
    test_full_buffer();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end
endmodule
